// File: rtl/vid_stream_rx.sv
// ---------------------------------------------------------------------------
// vid_stream_rx
//   Clocked-video receiver. Registers the parallel RGB video pins once,
//   aligns to v_sync, and packs each frame into an Avalon-ST video packet:
//   a type-0 header beat carrying SOP, then ACTIVE_W*ACTIVE_H pixels with
//   EOP on the last one. Packets leave through a show-ahead FIFO towards a
//   ready/valid sink. Frames that end early are closed with a zero
//   terminator beat carrying EOP, so the sink always sees a closed packet.
//
// Parameters
//   ACTIVE_W, ACTIVE_H : active pixels per line / active lines per frame
//   FIFO_DEPTH         : output FIFO entries (power of 2, >= 4)
//
// Ports
//   clk_50, reset_n         : clock, synchronous active-low reset
//   vid_data/datavalid/     : video input; h_sync is not used for alignment
//   vid_h_sync/vid_v_sync
//   dout_*                  : Avalon-ST source (data, valid, ready, SOP, EOP)
//   clr_status              : pulse, clears overflow and frame_err
//   overflow, frame_err     : sticky error flags
//   locked                  : two consecutive clean frames seen
//   frame_cnt               : clean-frame counter
//
// Build option
//   VID_RX_FRAME_CNT_EN : when defined, frame_cnt counts clean frames
//                         (wrapping); otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module vid_stream_rx #(
    parameter int ACTIVE_W   = 800,
    parameter int ACTIVE_H   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic [23:0] vid_data,
    input  logic        vid_datavalid,
    input  logic        vid_h_sync,
    input  logic        vid_v_sync,
    output logic [23:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_startofpacket,
    output logic        dout_endofpacket,
    input  logic        clr_status,
    output logic        overflow,
    output logic        frame_err,
    output logic        locked,
    output logic [15:0] frame_cnt
);

    localparam int FRAME_PIX = ACTIVE_W * ACTIVE_H;
    localparam int PIX_W     = $clog2(FRAME_PIX + 1);
    localparam int LPIX_W    = $clog2(ACTIVE_W + 1);
    localparam int LINE_W    = $clog2(ACTIVE_H + 1);
    localparam int AW        = $clog2(FIFO_DEPTH);

    localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(FRAME_PIX - 1);
    localparam logic [LPIX_W-1:0] LPIX_MAX = LPIX_W'(ACTIVE_W);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(ACTIVE_H);

    typedef enum logic [1:0] {WAIT_VS, HDR, ACTIVE, DROP} state_e;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [23:0] data;
    } beat_t;

    // Input stage S1 and its one-cycle-old copy for edge detection.
    logic [23:0] vdata_q;
    logic        dv_q, hs_q, vs_q, dv_prev_q, vs_prev_q;

    state_e             state_q, state_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LPIX_W-1:0]  line_pix_q, line_pix_d;
    logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
    logic               closed_q, closed_d;       // EOP written or terminator queued
    logic               term_pend_q, term_pend_d;
    logic               vsf_pend_q, vsf_pend_d;   // v_sync fell while terminator waits
    logic               frame_bad_q, frame_bad_d;
    logic               overflow_q, overflow_d;
    logic               frame_err_q, frame_err_d;
    logic [1:0]         clean_cnt_q, clean_cnt_d;

    logic               wr_en, rd_en, empty, full, no_room;
    beat_t              wr_beat, head;
    logic               err_ev, ovf_ev, eop_full, clean_ev;
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    beat_t              mem_q [FIFO_DEPTH];

    logic unused_hsync;
    assign unused_hsync = hs_q;

    wire vs_rise  =  vs_q & ~vs_prev_q;
    wire vs_fall  = ~vs_q &  vs_prev_q;
    wire pix_in   =  dv_q & ~vs_q;
    wire line_end =  dv_prev_q & ~dv_q & ~vs_q;

    // FIFO status. A read in the same cycle frees a slot, so a write at full
    // still succeeds when the sink is draining.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en   = !empty && dout_ready;
    assign no_room = full && !rd_en;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        line_pix_d  = line_pix_q;
        line_cnt_d  = line_cnt_q;
        closed_d    = closed_q;
        term_pend_d = term_pend_q;
        vsf_pend_d  = vsf_pend_q;
        frame_bad_d = frame_bad_q;
        wr_en       = 1'b0;
        wr_beat     = '0;
        err_ev      = 1'b0;
        ovf_ev      = 1'b0;
        eop_full    = 1'b0;

        case (state_q)
            WAIT_VS: if (vs_fall) state_d = HDR;

            HDR: begin
                // The write port belongs to the header here; any pixel is lost.
                if (pix_in) err_ev = 1'b1;
                if (!no_room) begin
                    wr_en       = 1'b1;
                    wr_beat.sop = 1'b1;
                    pix_cnt_d   = '0;
                    line_pix_d  = '0;
                    line_cnt_d  = '0;
                    closed_d    = 1'b0;
                    vsf_pend_d  = 1'b0;
                    frame_bad_d = 1'b0;
                    state_d     = ACTIVE;
                end
            end

            ACTIVE, DROP: begin
                if (state_q == ACTIVE) begin
                    if (pix_in) begin
                        // Counter stops at ACTIVE_W; one more pixel is a long line.
                        if (line_pix_q == LPIX_MAX) err_ev = 1'b1;
                        else                        line_pix_d = line_pix_q + 1'b1;
                        if (closed_q) begin
                            err_ev = 1'b1;
                        end else if (no_room) begin
                            ovf_ev  = 1'b1;
                            state_d = DROP;
                        end else begin
                            wr_en        = 1'b1;
                            wr_beat.data = vdata_q;
                            wr_beat.eop  = (pix_cnt_q == LAST_PIX);
                            pix_cnt_d    = pix_cnt_q + 1'b1;
                            if (pix_cnt_q == LAST_PIX) begin
                                closed_d = 1'b1;
                                eop_full = 1'b1;
                            end
                        end
                    end
                    if (line_end) begin
                        if (line_pix_q != LPIX_MAX) err_ev = 1'b1;
                        if (line_cnt_q == LINE_MAX) err_ev = 1'b1;
                        else                        line_cnt_d = line_cnt_q + 1'b1;
                        line_pix_d = '0;
                    end
                end
                // Frame ended before its EOP: close the packet with a terminator.
                if (vs_rise && !closed_q) begin
                    if (state_q == ACTIVE) err_ev = 1'b1;
                    term_pend_d = 1'b1;
                    closed_d    = 1'b1;
                end
                if (vs_fall) vsf_pend_d = 1'b1;
                if (term_pend_q && !no_room && !wr_en) begin
                    wr_en       = 1'b1;
                    wr_beat.eop = 1'b1;
                    term_pend_d = 1'b0;
                end
                // Next header only once any terminator has gone into the FIFO.
                if ((vs_fall || vsf_pend_q) && !term_pend_q) state_d = HDR;
            end

            default: state_d = WAIT_VS;
        endcase

        if (err_ev || ovf_ev) frame_bad_d = 1'b1;
        clean_ev = eop_full && !frame_bad_q && !err_ev;

        // Same-cycle event beats clr_status.
        overflow_d  = ovf_ev | (overflow_q  & ~clr_status);
        frame_err_d = err_ev | (frame_err_q & ~clr_status);

        clean_cnt_d = clean_cnt_q;
        if (err_ev || ovf_ev)                     clean_cnt_d = 2'd0;
        else if (clean_ev && clean_cnt_q != 2'd2) clean_cnt_d = clean_cnt_q + 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            vdata_q     <= '0;
            dv_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            dv_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            state_q     <= WAIT_VS;
            pix_cnt_q   <= '0;
            line_pix_q  <= '0;
            line_cnt_q  <= '0;
            closed_q    <= 1'b0;
            term_pend_q <= 1'b0;
            vsf_pend_q  <= 1'b0;
            frame_bad_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            clean_cnt_q <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            vdata_q     <= vid_data;
            dv_q        <= vid_datavalid;
            hs_q        <= vid_h_sync;
            vs_q        <= vid_v_sync;
            dv_prev_q   <= dv_q;
            vs_prev_q   <= vs_q;
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            line_pix_q  <= line_pix_d;
            line_cnt_q  <= line_cnt_d;
            closed_q    <= closed_d;
            term_pend_q <= term_pend_d;
            vsf_pend_q  <= vsf_pend_d;
            frame_bad_q <= frame_bad_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            clean_cnt_q <= clean_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers define which entries are
    // valid, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk_50) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_beat;
    end

    // Show-ahead output; gated so the bus reads zero whenever it is empty.
    assign head               = mem_q[rd_ptr_q[AW-1:0]];
    assign dout_valid         = !empty;
    assign dout_data          = empty ? 24'h0 : head.data;
    assign dout_startofpacket = !empty && head.sop;
    assign dout_endofpacket   = !empty && head.eop;
    assign overflow           = overflow_q;
    assign frame_err          = frame_err_q;
    assign locked             = (clean_cnt_q == 2'd2);

`ifdef VID_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk_50) begin
        if (!reset_n)      frame_cnt_q <= 16'h0000;
        else if (clean_ev) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vid_stream_rx.sv
// ---------------------------------------------------------------------------
// tb_vid_stream_rx
//   Directed bench for vid_stream_rx with a 4x2 frame and a 4-entry FIFO.
//   A negedge monitor collects transferred beats and checks that a stalled
//   output holds still; frames are compared against hand-built beat lists.
// ---------------------------------------------------------------------------
module tb_vid_stream_rx;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic [23:0] vid_data;
    logic        vid_datavalid, vid_h_sync, vid_v_sync;
    logic [23:0] dout_data;
    logic        dout_valid, dout_ready, dout_startofpacket, dout_endofpacket;
    logic        clr_status, overflow, frame_err, locked;
    logic [15:0] frame_cnt;

    always #5 clk_50 = ~clk_50;

    vid_stream_rx #(.ACTIVE_W(4), .ACTIVE_H(2), .FIFO_DEPTH(4)) dut (
        .clk_50             (clk_50),
        .reset_n            (reset_n),
        .vid_data           (vid_data),
        .vid_datavalid      (vid_datavalid),
        .vid_h_sync         (vid_h_sync),
        .vid_v_sync         (vid_v_sync),
        .dout_data          (dout_data),
        .dout_valid         (dout_valid),
        .dout_ready         (dout_ready),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket),
        .clr_status         (clr_status),
        .overflow           (overflow),
        .frame_err          (frame_err),
        .locked             (locked),
        .frame_cnt          (frame_cnt)
    );

`ifdef VID_RX_FRAME_CNT_EN
    localparam logic [15:0] CNT_MASK = 16'hFFFF;
`else
    localparam logic [15:0] CNT_MASK = 16'h0000;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [25:0] got_q [$];
    logic [25:0] exp_q [$];
    logic        rand_rdy   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_out   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [25:0] mk(input logic s, input logic e, input logic [23:0] d);
        return {s, e, d};
    endfunction

    function automatic logic [15:0] fc_exp(input int n);
        return 16'(n) & CNT_MASK;
    endfunction

    // Transfers are decided at the next posedge; inputs settle by the negedge.
    always @(negedge clk_50) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold",
                      {5'd0, dout_valid, dout_startofpacket, dout_endofpacket, dout_data},
                      {5'd0, prev_out});
            if (dout_valid && dout_ready)
                got_q.push_back({dout_startofpacket, dout_endofpacket, dout_data});
            prev_stall = dout_valid && !dout_ready;
            prev_out   = {dout_valid, dout_startofpacket, dout_endofpacket, dout_data};
        end
    end

    // Drive pins for the coming edge, then return just after that edge.
    task automatic step(input logic vs, input logic dv, input logic [23:0] d);
        vid_v_sync    = vs;
        vid_datavalid = dv;
        vid_data      = d;
        vid_h_sync    = ~dv & ~vs;
        if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
        @(posedge clk_50);
        #1;
    endtask

    // v_sync pulse, lead-in gap, two lines (second one n2 pixels long).
    task automatic send_frame(input int n2, input int lead, input int lg, input bit chk_lat);
        repeat (2) step(1'b1, 1'b0, 24'h0);
        for (int i = 1; i <= lead; i++) begin
            step(1'b0, 1'b0, 24'h0);
            if (chk_lat && i == 2) check("hdr_lat_early", {31'd0, dout_valid}, 32'd0);
            if (chk_lat && i == 3)
                check("hdr_lat_sop", {30'd0, dout_valid, dout_startofpacket}, 32'd3);
        end
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < ((l == 0) ? 4 : n2); i++)
                step(1'b0, 1'b1, 24'(l * 4 + i + 1));
            repeat (lg) step(1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic end_frame();
        repeat (6) step(1'b1, 1'b0, 24'h0);
    endtask

    task automatic exp_frame(input int n2, input bit term);
        exp_q.push_back(mk(1'b1, 1'b0, 24'h0));
        for (int i = 1; i <= 4 + n2; i++) exp_q.push_back(mk(1'b0, i == 8, 24'(i)));
        if (term) exp_q.push_back(mk(1'b0, 1'b1, 24'h0));
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), {6'd0, got_q[i]}, {6'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_sop_eop"}, {30'd0, dout_startofpacket, dout_endofpacket}, 32'd0);
        check({tag, "_data"}, {8'd0, dout_data}, 32'd0);
        check({tag, "_flags"}, {29'd0, overflow, frame_err, locked}, 32'd0);
        check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        dout_ready    = 1'b1;
        clr_status    = 1'b0;
        vid_v_sync    = 1'b0;
        vid_datavalid = 1'b0;
        vid_data      = 24'h0;
        vid_h_sync    = 1'b0;
        repeat (2) step(1'b0, 1'b0, 24'h0);
        check_idle("reset");
        reset_n = 1'b1;

        // Clean frame, with header latency checked on the way.
        send_frame(4, 4, 6, 1'b1);
        end_frame();
        exp_frame(4, 1'b0);
        compare_beats("frame1");
        check("frame1_err", {31'd0, frame_err}, 32'd0);
        check("frame1_locked", {31'd0, locked}, 32'd0);

        // Second clean frame locks.
        send_frame(4, 4, 6, 1'b0);
        end_frame();
        exp_frame(4, 1'b0);
        compare_beats("frame2");
        check("frame2_locked", {31'd0, locked}, 32'd1);
        check("frame2_cnt", {16'd0, frame_cnt}, {16'd0, fc_exp(2)});

        // Short second line: 7 pixels, then a zero terminator with EOP.
        send_frame(3, 4, 6, 1'b0);
        end_frame();
        exp_frame(3, 1'b1);
        compare_beats("short");
        check("short_err", {31'd0, frame_err}, 32'd1);
        check("short_locked", {31'd0, locked}, 32'd0);

        // Sink stalled for a whole frame: header + 3 pixels fill the FIFO.
        dout_ready = 1'b0;
        send_frame(4, 4, 6, 1'b0);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        dout_ready = 1'b1;
        repeat (6) step(1'b0, 1'b0, 24'h0);
        end_frame();
        exp_q.push_back(mk(1'b1, 1'b0, 24'h0));
        for (int i = 1; i <= 3; i++) exp_q.push_back(mk(1'b0, 1'b0, 24'(i)));
        exp_q.push_back(mk(1'b0, 1'b1, 24'h0));
        compare_beats("ovf");

        // Random backpressure: stream must match a clean frame exactly.
        rand_rdy = 1'b1;
        send_frame(4, 20, 40, 1'b0);
        rand_rdy   = 1'b0;
        dout_ready = 1'b1;
        end_frame();
        exp_frame(4, 1'b0);
        compare_beats("bp");

        // Another clean frame locks again; clr_status leaves locked alone.
        send_frame(4, 4, 6, 1'b0);
        end_frame();
        exp_frame(4, 1'b0);
        compare_beats("frame6");
        check("frame6_locked", {31'd0, locked}, 32'd1);
        check("frame6_cnt", {16'd0, frame_cnt}, {16'd0, fc_exp(4)});
        check("pre_clr_flags", {30'd0, overflow, frame_err}, 32'd3);
        clr_status = 1'b1;
        step(1'b1, 1'b0, 24'h0);
        clr_status = 1'b0;
        check("clr_flags", {30'd0, overflow, frame_err}, 32'd0);
        check("clr_locked", {31'd0, locked}, 32'd1);

        // Reset for one cycle mid-line.
        repeat (2) step(1'b1, 1'b0, 24'h0);
        repeat (4) step(1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b1, 24'd1);
        step(1'b0, 1'b1, 24'd2);
        reset_n = 1'b0;
        step(1'b0, 1'b1, 24'd3);
        check_idle("rst_mid");
        reset_n = 1'b1;
        got_q.delete();
        step(1'b0, 1'b1, 24'd4);
        repeat (6) step(1'b0, 1'b0, 24'h0);
        for (int i = 5; i <= 8; i++) step(1'b0, 1'b1, 24'(i));
        repeat (6) step(1'b0, 1'b0, 24'h0);
        check("no_beats_after_reset", got_q.size(), 32'd0);
        end_frame();
        send_frame(4, 4, 6, 1'b0);
        end_frame();
        exp_frame(4, 1'b0);
        compare_beats("post_rst");
        check("post_rst_cnt", {16'd0, frame_cnt}, {16'd0, fc_exp(1)});
        check("post_rst_locked", {31'd0, locked}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
